// File: rtl/bcd_display_mux.sv
// Multiplexed 7-segment driver for a packed BCD word. A new word is taken on a
// load strobe and becomes visible only at a frame boundary, so a frame never mixes two values.
module bcd_display_mux #(
  parameter int OUTPUT_DIGITS = 3,
  parameter int CLOCK_HZ      = 1_000_000,
  parameter int DWELL_US      = 1000
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Load_i,
  input  logic [OUTPUT_DIGITS*4-1:0] BCD_i,
  output logic [6:0]                 Segments_o,
  output logic [OUTPUT_DIGITS-1:0]   Digits_o
);

  localparam int TICKS = CLOCK_HZ / 1_000_000 * DWELL_US;
  localparam int PRE_W = $clog2(TICKS);
  localparam int IDX_W = (OUTPUT_DIGITS > 1) ? $clog2(OUTPUT_DIGITS) : 1;
  localparam int BCD_W = OUTPUT_DIGITS * 4;

  logic [PRE_W-1:0]         prescaler_q, prescaler_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic [BCD_W-1:0]         pending_q, pending_d;
  logic                     pending_valid_q, pending_valid_d;
  logic [BCD_W-1:0]         shown_q, shown_d;
  logic                     shown_valid_q, shown_valid_d;
  logic [6:0]               segments_q, segments_d;
  logic [OUTPUT_DIGITS-1:0] digits_q, digits_d;

  logic                     tick_end;
  logic                     frame_end;
  logic [3:0]               digit_w [OUTPUT_DIGITS];
  logic [OUTPUT_DIGITS-1:0] blank_w;
  logic [OUTPUT_DIGITS:0]   zero_above;
  logic [3:0]               cur_digit;
  logic                     cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  assign tick_end  = (prescaler_q == PRE_W'(TICKS - 1));
  assign frame_end = tick_end && (index_q == IDX_W'(OUTPUT_DIGITS - 1));

  // zero_above[k] is set when digit k and every digit above it are zero.
  assign zero_above[OUTPUT_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < OUTPUT_DIGITS; gi++) begin : g_digit
    assign digit_w[gi]    = shown_q[gi*4 +: 4];
    assign zero_above[gi] = zero_above[gi+1] && (digit_w[gi] == 4'd0);
    if (gi == 0) begin : g_units
      assign blank_w[gi] = 1'b0;
    end else begin : g_upper
      assign blank_w[gi] = zero_above[gi];
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    digits_d  = '0;
    for (int k = 0; k < OUTPUT_DIGITS; k++) begin
      if (index_q == IDX_W'(k)) begin
        cur_digit   = digit_w[k];
        cur_blank   = blank_w[k];
        digits_d[k] = 1'b1;
      end
    end
    segments_d = (!shown_valid_q || cur_blank) ? 7'h00 : seg_decode(cur_digit);
  end

  always_comb begin
    prescaler_d     = tick_end ? '0 : prescaler_q + 1'b1;
    index_d         = index_q;
    if (tick_end) begin
      index_d = frame_end ? '0 : index_q + 1'b1;
    end
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    shown_d         = shown_q;
    shown_valid_d   = shown_valid_q;
    // A load landing on the boundary edge bypasses Pending and drops any older value.
    if (frame_end && Load_i) begin
      shown_d         = BCD_i;
      shown_valid_d   = 1'b1;
      pending_valid_d = 1'b0;
    end else if (frame_end && pending_valid_q) begin
      shown_d         = pending_q;
      shown_valid_d   = 1'b1;
      pending_valid_d = 1'b0;
    end else if (Load_i) begin
      pending_d       = BCD_i;
      pending_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prescaler_q     <= '0;
      index_q         <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      shown_q         <= '0;
      shown_valid_q   <= 1'b0;
      segments_q      <= '0;
      digits_q        <= '0;
    end else begin
      prescaler_q     <= prescaler_d;
      index_q         <= index_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      shown_q         <= shown_d;
      shown_valid_q   <= shown_valid_d;
      segments_q      <= segments_d;
      digits_q        <= digits_d;
    end
  end

  assign Segments_o = segments_q;
  assign Digits_o   = digits_q;

endmodule
